// File: rtl/eth_egress_arbiter.sv
// Packet-level round-robin arbiter (optional port-0 strict priority) merging framed AXI-Stream sources onto one egress.
// Define ETH_EGRESS_ARB_STATS_EN to build per-port packet counters behind the regport.
module eth_egress_arbiter #(
  parameter int                NUM_PORTS = 3,
  parameter int                DWIDTH    = 64,
  parameter int                UWIDTH    = 4,
  parameter bit                PRIO0     = 1'b1,
  parameter int                AWIDTH    = 14,
  parameter logic [AWIDTH-1:0] BASE      = 14'h2000
) (
  input  logic                        bus_clk,
  input  logic                        bus_rst,
  input  logic [NUM_PORTS*DWIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*UWIDTH-1:0] s_tuser,
  input  logic [NUM_PORTS-1:0]        s_tlast,
  input  logic [NUM_PORTS-1:0]        s_tvalid,
  output logic [NUM_PORTS-1:0]        s_tready,
  output logic [DWIDTH-1:0]           m_tdata,
  output logic [UWIDTH-1:0]           m_tuser,
  output logic                        m_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [2:0]                  active_port,
  output logic                        busy,
  input  logic                        reg_wr_req,
  input  logic [AWIDTH-1:0]           reg_wr_addr,
  input  logic [31:0]                 reg_wr_data,
  input  logic                        reg_rd_req,
  input  logic [AWIDTH-1:0]           reg_rd_addr,
  output logic                        reg_rd_resp,
  output logic [31:0]                 reg_rd_data
);

  typedef enum logic {IDLE, PASS} state_t;

  state_t     state_q;
  logic [2:0] grant_q;
  logic [2:0] last_grant_q;
  logic [2:0] pick_d;
  logic       found;
  logic       sel_valid;
  logic       pkt_done;
  int         idx;

  // Next grant: port 0 first when prioritised, else first requester after last_grant_q.
  always_comb begin
    pick_d = '0;
    found  = 1'b0;
    idx    = 0;
    if (PRIO0 && s_tvalid[0]) begin
      pick_d = '0;
      found  = 1'b1;
    end
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_grant_q) + k) % NUM_PORTS;
      if (!found && s_tvalid[idx]) begin
        pick_d = 3'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    m_tdata   = '0;
    m_tuser   = '0;
    m_tlast   = 1'b0;
    sel_valid = 1'b0;
    s_tready  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 3'(i)) begin
        m_tdata   = s_tdata[i*DWIDTH +: DWIDTH];
        m_tuser   = s_tuser[i*UWIDTH +: UWIDTH];
        m_tlast   = s_tlast[i];
        sel_valid = s_tvalid[i];
        s_tready[i] = (state_q == PASS) && m_tready;
      end
    end
    m_tvalid = (state_q == PASS) && sel_valid;
    pkt_done = m_tvalid && m_tready && m_tlast;
  end

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= 3'(NUM_PORTS - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|s_tvalid) begin
            grant_q <= pick_d;
            state_q <= PASS;
          end
        end
        PASS: begin
          if (pkt_done) begin
            last_grant_q <= grant_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = (state_q == PASS);
  assign active_port = grant_q;

`ifdef ETH_EGRESS_ARB_STATS_EN
  localparam logic [AWIDTH-1:0] CLR_ADDR = BASE + AWIDTH'(32'h20);

  logic [31:0] cnt_q [NUM_PORTS];
  logic        rd_resp_q;
  logic [31:0] rd_data_q;
  logic        clr_hit;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        unused_regport;

  always_comb begin
    clr_hit = reg_wr_req && (reg_wr_addr == CLR_ADDR);
    rd_hit  = 1'b0;
    rd_val  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reg_rd_addr == BASE + AWIDTH'(4 * i)) begin
        rd_hit = reg_rd_req;
        rd_val = cnt_q[i];
      end
    end
  end

  // A clear on the same cycle as a packet end takes precedence.
  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
      rd_resp_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (clr_hit)
          cnt_q[i] <= '0;
        else if (pkt_done && (grant_q == 3'(i)))
          cnt_q[i] <= cnt_q[i] + 32'd1;
      end
      rd_resp_q <= rd_hit;
      rd_data_q <= rd_hit ? rd_val : '0;
    end
  end

  assign reg_rd_resp    = rd_resp_q;
  assign reg_rd_data    = rd_data_q;
  assign unused_regport = ^reg_wr_data;
`else
  logic unused_regport;

  assign reg_rd_resp    = 1'b0;
  assign reg_rd_data    = '0;
  assign unused_regport = ^{reg_wr_req, reg_wr_addr, reg_wr_data, reg_rd_req, reg_rd_addr};
`endif

endmodule
